// File: rtl/vertebrate_bus_responder.sv
// CPU memory-bus responder: word RAM below IO_BASE plus an I/O page with switches,
// LEDs, a prescaled timer and a byte transmit FIFO drained over valid/ready.
module vertebrate_bus_responder #(
  parameter int unsigned RAM_AW      = 10,
  parameter logic [15:0] IO_BASE     = 16'hFF00,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMER_PRESC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic [15:0] wr_data,
  input  logic        memwt,
  output logic [15:0] rd_data,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW        = $clog2(TIMER_PRESC);

  localparam logic [15:0] OFF_SW    = 16'd0;
  localparam logic [15:0] OFF_LED   = 16'd1;
  localparam logic [15:0] OFF_TCNT  = 16'd2;
  localparam logic [15:0] OFF_TSTAT = 16'd3;
  localparam logic [15:0] OFF_TXD   = 16'd4;
  localparam logic [15:0] OFF_TXS   = 16'd5;

  logic [15:0] ram_q [RAM_DEPTH];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic [15:0] sync1_q, sync1_d, sw_sync_q, sw_sync_d;
  logic [15:0] led_q, led_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        tick_q, tick_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic        ovf_q, ovf_d;

  logic        is_io_c, wr_en_c;
  logic [15:0] io_off_c;
  logic        wr_led_c, wr_tcnt_c, wr_tstat_c, wr_txd_c, wr_txs_c;
  logic        wrap_c, full_c, empty_c, pop_c, push_ok_c, ovf_set_c;

  // Address decode; writes are suppressed while reset is asserted
  assign is_io_c    = (address >= IO_BASE);
  assign io_off_c   = address - IO_BASE;
  assign wr_en_c    = memwt & rst_n;
  assign wr_led_c   = wr_en_c & is_io_c & (io_off_c == OFF_LED);
  assign wr_tcnt_c  = wr_en_c & is_io_c & (io_off_c == OFF_TCNT);
  assign wr_tstat_c = wr_en_c & is_io_c & (io_off_c == OFF_TSTAT);
  assign wr_txd_c   = wr_en_c & is_io_c & (io_off_c == OFF_TXD);
  assign wr_txs_c   = wr_en_c & is_io_c & (io_off_c == OFF_TXS);

  assign wrap_c    = (presc_q == TW'(TIMER_PRESC - 1));
  assign full_c    = (count_q == CW'(FIFO_DEPTH));
  assign empty_c   = (count_q == '0);
  assign pop_c     = ~empty_c & tx_ready;
  assign push_ok_c = wr_txd_c & (~full_c | pop_c);
  assign ovf_set_c = wr_txd_c & full_c & ~pop_c;

  assign led_out  = led_q;
  assign tx_valid = ~empty_c;
  assign tx_data  = empty_c ? 8'h00 : fifo_q[rptr_q];

  always_comb begin
    sync1_d   = sw_in;
    sw_sync_d = sync1_q;
    led_d     = wr_led_c ? wr_data : led_q;

    presc_d = wrap_c ? '0 : presc_q + TW'(1);
    tcnt_d  = wrap_c ? tcnt_q + 16'd1 : tcnt_q;
    if (wr_tcnt_c) begin
      presc_d = '0;
      tcnt_d  = '0;
    end

    // Sticky flags: a same-cycle set beats the clear
    tick_d = tick_q;
    if (wrap_c)                         tick_d = 1'b1;
    else if (wr_tstat_c && wr_data[0])  tick_d = 1'b0;

    ovf_d = ovf_q;
    if (ovf_set_c)                      ovf_d = 1'b1;
    else if (wr_txs_c && wr_data[2])    ovf_d = 1'b0;

    wptr_d  = push_ok_c ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_c ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok_c && !pop_c)      count_d = count_q + CW'(1);
    else if (!push_ok_c && pop_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      presc_q   <= '0;
      tcnt_q    <= '0;
      tick_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sw_sync_q <= sw_sync_d;
      led_q     <= led_d;
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays carry no reset; RAM contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_en_c && !is_io_c) ram_q[address[RAM_AW-1:0]] <= wr_data;
    if (push_ok_c)           fifo_q[wptr_q] <= wr_data[7:0];
  end

  always_comb begin
    rd_data = 16'h0000;
    if (!is_io_c) begin
      rd_data = ram_q[address[RAM_AW-1:0]];
    end else begin
      case (io_off_c)
        OFF_SW:    rd_data = sw_sync_q;
        OFF_LED:   rd_data = led_q;
        OFF_TCNT:  rd_data = tcnt_q;
        OFF_TSTAT: rd_data = {15'h0000, tick_q};
        OFF_TXS:   rd_data = {7'h00, 5'(count_q), 1'b0, ovf_q, empty_c, full_c};
        default:   rd_data = 16'h0000;
      endcase
    end
  end
endmodule
